// File: rtl/tx_block_unloader_pkg.sv
// rtl/tx_block_unloader_pkg.sv - shared types and sizing for the Tx block unloader
// Purpose: FSM state encoding, default geometry and the beat counter width helper.
// Ports: none (package).
package tx_block_unloader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } tx_unl_state_t;

  localparam int BLOCK_W_DEFAULT = 64;
  localparam int OUT_W_DEFAULT   = 8;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int BEATS_PER_BLOCK = BLOCK_W_DEFAULT / OUT_W_DEFAULT;
  localparam int BEAT_CNT_W      = $clog2(BEATS_PER_BLOCK);

  // A block of a single beat still needs a 1-bit counter to stay legal.
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/tx_block_unloader_shift_reg.sv
// rtl/tx_block_unloader_shift_reg.sv - block-wide shift register serialising MSB slice first
// Purpose: holds one cipher block; parallel load, shift left by OUT_W per accepted beat.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        capture load_data (takes priority over shift)
//   load_data   BLOCK_W block to serialise
//   shift       drop the current MSB slice
//   msb_out     current OUT_W-wide MSB slice
module tx_shift_reg #(
  parameter int BLOCK_W = 64,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  output logic [OUT_W-1:0]   msb_out
);

  logic [BLOCK_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= shreg << OUT_W;
    end
  end

  assign msb_out = shreg[BLOCK_W-1 -: OUT_W];

endmodule

// File: rtl/tx_block_unloader.sv
// rtl/tx_block_unloader.sv - drains Tx FIFO blocks onto a byte-wide valid/ready stream
// Purpose: pops one block per transfer, emits it MSB beat first, counts completed blocks.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   emptyTx      Tx FIFO empty flag (sampled only while idle)
//   tx_rdata     Tx FIFO read data, valid the cycle after trans_deq
//   trans_deq    Tx FIFO pop strobe, one cycle per block
//   flush        abort the block in flight
//   out_data     current output beat
//   out_valid    out_data valid
//   out_ready    downstream accept
//   out_last     final beat of a block
//   busy         unloader not idle
//   blocks_sent  completed blocks since reset, wraps
module tx_block_unloader
  import tx_block_unloader_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEFAULT,
  parameter int OUT_W   = OUT_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               emptyTx,
  input  logic [BLOCK_W-1:0] tx_rdata,
  output logic               trans_deq,
  input  logic               flush,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_sent
);

  localparam int BEATS = BLOCK_W / OUT_W;
  localparam int BCW   = beat_cnt_width(BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  tx_unl_state_t state, state_next;
  logic [BCW-1:0]   beat_cnt;
  logic [CNT_W-1:0] blocks_sent_q;
  logic             handshake;
  logic             at_last;

  tx_shift_reg #(
    .BLOCK_W (BLOCK_W),
    .OUT_W   (OUT_W)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (state == S_LOAD),
    .load_data (tx_rdata),
    .shift     (handshake),
    .msb_out   (out_data)
  );

  assign at_last   = (beat_cnt == LAST_BEAT);
  assign handshake = (state == S_SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend on state/registers only; out_ready only steers the next state.
  always_comb begin
    state_next = state;
    trans_deq  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (!emptyTx) state_next = S_POP;
      end
      S_POP: begin
        // The pop is issued even when flushed; the popped block is simply dropped.
        trans_deq  = 1'b1;
        state_next = flush ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        state_next = flush ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = at_last;
        // A completing last beat beats a simultaneous flush.
        if ((handshake && at_last) || flush) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (state == S_LOAD) begin
      beat_cnt <= '0;
    end else if (handshake) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blocks_sent_q <= '0;
    end else if (handshake && at_last) begin
      blocks_sent_q <= blocks_sent_q + 1'b1;
    end
  end

  assign blocks_sent = blocks_sent_q;

endmodule
